// File: rtl/fetch_unit_v2_pkg.sv
// Shared widths, opcode constants, fetch-queue entry type and immediate decoders for fetch_unit_v2.
package fetch_unit_v2_pkg;
  localparam int AddrWidth  = 32;
  localparam int InstrWidth = 32;

  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [AddrWidth-1:0] ZERO = '0;

  typedef struct packed {
    logic [InstrWidth-1:0] instr;
    logic [AddrWidth-1:0]  pc;
    logic                  bp;
  } fq_entry_t;

  function automatic logic [AddrWidth-1:0] imm_j(input logic [InstrWidth-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [AddrWidth-1:0] imm_b(input logic [InstrWidth-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_unit_v2_bht.sv
// Branch history table: combinational lookup, one synchronous saturating update per cycle.
// Reset initialises every counter to weakly not-taken; a same-index update is seen by lookup next cycle.
module fetch_bht #(
  parameter int BHT_ENTRIES = 256,
  parameter int CTR_BITS    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx_i,
  output logic                           rd_taken_o,
  input  logic                           upd_en_i,
  input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx_i,
  input  logic                           upd_taken_i
);
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;

  logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] upd_cur;

  assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];
  assign upd_cur    = ctr_q[upd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CtrInit;
    end else if (upd_en_i) begin
      if (upd_taken_i && upd_cur != CtrMax)
        ctr_q[upd_idx_i] <= upd_cur + CTR_BITS'(1);
      else if (!upd_taken_i && upd_cur != '0)
        ctr_q[upd_idx_i] <= upd_cur - CTR_BITS'(1);
    end
  end
endmodule

// File: rtl/fetch_unit_v2.sv
// Fetch front end: one outstanding icache request, QDEPTH queue, BHT prediction; RAS when FETCH_RAS_EN is defined.
// Request/issue outputs are registered (1 cycle); stalls on rdy_in low, full queue or issue_to_if_en_in low.
module fetch_unit_v2
  import fetch_unit_v2_pkg::*;
#(
  parameter int          QDEPTH      = 16,
  parameter int          BHT_ENTRIES = 256,
  parameter int          CTR_BITS    = 2,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          RAS_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_to_icache_en_out,
  output logic [31:0] if_a_out,
  input  logic        icache_to_if_en_in,
  input  logic [31:0] if_d_in,
  input  logic        issue_to_if_en_in,
  output logic        if_to_issue_en_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        bp_out,
  input  logic        commit_to_if_en_in,
  input  logic [31:0] commit_to_if_pc_in,
  input  logic        commit_to_if_bpres_in,
  input  logic        clear_branch_in,
  input  logic [31:0] commit_to_pc_in
);
  localparam int QAw   = $clog2(QDEPTH);
  localparam int BhtAw = $clog2(BHT_ENTRIES);
  localparam logic [QAw:0] QCap = (QAw + 1)'(QDEPTH);

  logic [AddrWidth-1:0] pc_q, pc_d, req_a_q, req_a_d;
  logic [QAw:0]         count_q, count_d;
  logic [QAw-1:0]       head_q, head_d, tail_q, tail_d;
  logic                 busy_q, busy_d, drop_q, drop_d;
  logic                 req_q, req_d, iss_q, iss_d;
  fq_entry_t            out_q, out_d, push_ent;
  fq_entry_t            fq_q [QDEPTH];

  logic                 push, pop, pred, bht_taken;
  logic [AddrWidth-1:0] next_pc;
  logic [6:0]           opcode;
  logic                 unused_commit_pc;

  assign unused_commit_pc = ^{commit_to_if_pc_in[31:BhtAw+2], commit_to_if_pc_in[1:0]};

  fetch_bht #(
    .BHT_ENTRIES(BHT_ENTRIES),
    .CTR_BITS   (CTR_BITS)
  ) u_bht (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .rd_idx_i   (pc_q[BhtAw+1:2]),
    .rd_taken_o (bht_taken),
    .upd_en_i   (commit_to_if_en_in && (rdy_in || clear_branch_in)),
    .upd_idx_i  (commit_to_if_pc_in[BhtAw+1:2]),
    .upd_taken_i(commit_to_if_bpres_in)
  );

`ifdef FETCH_RAS_EN
  localparam int RasAw = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RasAw:0] RasCap = (RasAw + 1)'(RAS_DEPTH);

  logic [AddrWidth-1:0] ras_q [RAS_DEPTH];
  logic [RasAw-1:0]     ras_ptr_q, ras_ptr_inc, ras_ptr_dec;
  logic [RasAw:0]       ras_cnt_q;
  logic                 ras_push, ras_pop;

  assign ras_ptr_inc = (ras_ptr_q == RasAw'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + RasAw'(1);
  assign ras_ptr_dec = (ras_ptr_q == '0) ? RasAw'(RAS_DEPTH - 1) : ras_ptr_q - RasAw'(1);
`endif

  // Next-pc and prediction for the instruction currently returning from the icache.
  always_comb begin
    opcode  = if_d_in[6:0];
    next_pc = pc_q + 32'd4;
    pred    = FALSE;
`ifdef FETCH_RAS_EN
    ras_push = FALSE;
    ras_pop  = FALSE;
`endif
    case (opcode)
      JAL: begin
        pred    = TRUE;
        next_pc = pc_q + imm_j(if_d_in);
`ifdef FETCH_RAS_EN
        ras_push = (if_d_in[11:7] == 5'd1) || (if_d_in[11:7] == 5'd5);
`endif
      end
      BRANCH: begin
        pred = bht_taken;
        if (bht_taken) next_pc = pc_q + imm_b(if_d_in);
      end
`ifdef FETCH_RAS_EN
      JALR: begin
        if (((if_d_in[19:15] == 5'd1) || (if_d_in[19:15] == 5'd5)) &&
            (if_d_in[11:7] == 5'd0) && (ras_cnt_q != '0)) begin
          pred    = TRUE;
          next_pc = ras_q[ras_ptr_dec];
          ras_pop = TRUE;
        end
      end
`endif
      default: ;
    endcase
  end

  assign push_ent = '{instr: if_d_in, pc: pc_q, bp: pred};

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    busy_d  = busy_q;
    drop_d  = drop_q;
    req_d   = req_q;
    req_a_d = req_a_q;
    iss_d   = iss_q;
    out_d   = out_q;
    push    = FALSE;
    pop     = FALSE;
    if (clear_branch_in) begin
      pc_d    = commit_to_pc_in;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      req_d   = FALSE;
      iss_d   = FALSE;
      drop_d  = busy_q && !icache_to_if_en_in ? TRUE : drop_q && !icache_to_if_en_in;
      if (busy_q && icache_to_if_en_in) busy_d = FALSE;
    end else if (rdy_in) begin
      req_d = FALSE;
      iss_d = FALSE;
      if (busy_q && icache_to_if_en_in) begin
        busy_d = FALSE;
        if (drop_q) begin
          drop_d = FALSE;
        end else begin
          push = TRUE;
          pc_d = next_pc;
        end
      end else if (!busy_q && !drop_q && count_q < QCap) begin
        req_d   = TRUE;
        req_a_d = pc_q;
        busy_d  = TRUE;
      end
      if (count_q != '0 && issue_to_if_en_in) begin
        pop    = TRUE;
        iss_d  = TRUE;
        out_d  = fq_q[head_q];
        head_d = head_q + QAw'(1);
      end
      if (push) tail_d = tail_q + QAw'(1);
      count_d = count_q + (QAw + 1)'(push) - (QAw + 1)'(pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= FALSE;
      drop_q  <= FALSE;
      req_q   <= FALSE;
      req_a_q <= ZERO;
      iss_q   <= FALSE;
      out_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      req_a_q <= req_a_d;
      iss_q   <= iss_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fq_q[tail_q] <= push_ent;
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (clear_branch_in) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (push && ras_push) begin
      ras_ptr_q <= ras_ptr_inc;
      if (ras_cnt_q != RasCap) ras_cnt_q <= ras_cnt_q + (RasAw + 1)'(1);
    end else if (push && ras_pop) begin
      ras_ptr_q <= ras_ptr_dec;
      ras_cnt_q <= ras_cnt_q - (RasAw + 1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && ras_push && !clear_branch_in) ras_q[ras_ptr_q] <= pc_q + 32'd4;
  end
`endif

  assign if_to_icache_en_out = req_q;
  assign if_a_out            = req_a_q;
  assign if_to_issue_en_out  = iss_q;
  assign instr_out           = out_q.instr;
  assign pc_out              = out_q.pc;
  assign bp_out              = out_q.bp;
endmodule

// File: tb/tb_fetch_unit_v2.sv
// Directed bench for fetch_unit_v2 (QDEPTH=4): fetch order, prediction, BHT saturation, full queue, clear/drop, reset.
module tb_fetch_unit_v2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        ic_req;
  logic [31:0] ic_a;
  logic        ic_vld = 1'b0;
  logic [31:0] ic_d = 32'h0;
  logic        iss_rdy = 1'b0;
  logic        iss_vld;
  logic [31:0] instr_o, pc_o;
  logic        bp_o;
  logic        cm_en = 1'b0;
  logic [31:0] cm_pc = 32'h0;
  logic        cm_res = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] clr_pc = 32'h0;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] ADDI3 = 32'h00300193;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] RET   = 32'h00008067;
  localparam logic [31:0] BEQ20 = 32'h02000063;  // beq x0,x0,+0x20
  localparam logic [31:0] JMP_M = 32'hF21FF06F;  // jal x0,-0xE0
  localparam logic [31:0] JAL16 = 32'h010000EF;  // jal x1,+16

`ifdef FETCH_RAS_EN
  localparam logic [31:0] RET_PC = 32'h24;
  localparam logic        RET_BP = 1'b1;
`else
  localparam logic [31:0] RET_PC = 32'h34;
  localparam logic        RET_BP = 1'b0;
`endif

  fetch_unit_v2 #(.QDEPTH(4)) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .rdy_in               (rdy),
    .if_to_icache_en_out  (ic_req),
    .if_a_out             (ic_a),
    .icache_to_if_en_in   (ic_vld),
    .if_d_in              (ic_d),
    .issue_to_if_en_in    (iss_rdy),
    .if_to_issue_en_out   (iss_vld),
    .instr_out            (instr_o),
    .pc_out               (pc_o),
    .bp_out               (bp_o),
    .commit_to_if_en_in   (cm_en),
    .commit_to_if_pc_in   (cm_pc),
    .commit_to_if_bpres_in(cm_res),
    .clear_branch_in      (clr),
    .commit_to_pc_in      (clr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] jal_enc(input logic [4:0] rd, input logic [31:0] off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_a, input int budget);
    int n = 0;
    while (!ic_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'b0, ic_req}, 32'd1);
    check({tag, "_addr"}, ic_a, exp_a);
  endtask

  task automatic respond(input logic [31:0] d);
    ic_vld = 1'b1;
    ic_d   = d;
    @(negedge clk);
    ic_vld = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] ei, input logic [31:0] ep, input logic eb);
    iss_rdy = 1'b1;
    @(negedge clk);
    iss_rdy = 1'b0;
    check({tag, "_vld"}, {31'b0, iss_vld}, 32'd1);
    check({tag, "_instr"}, instr_o, ei);
    check({tag, "_pc"}, pc_o, ep);
    check({tag, "_bp"}, {31'b0, bp_o}, {31'b0, eb});
  endtask

  task automatic commit(input logic [31:0] pc, input logic taken);
    cm_en  = 1'b1;
    cm_pc  = pc;
    cm_res = taken;
    @(negedge clk);
    cm_en  = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_req"}, {31'b0, ic_req}, 32'd0);
    check({tag, "_addr"}, ic_a, 32'd0);
    check({tag, "_iss"}, {31'b0, iss_vld}, 32'd0);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
    check({tag, "_bp"}, {31'b0, bp_o}, 32'd0);
  endtask

  initial begin
    int seen;
    // reset state, then stalled release
    #3;
    outs_zero("rst");
    @(negedge clk);
    rdy   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_noreq", {31'b0, ic_req}, 32'd0);
    rdy = 1'b1;

    // sequential fetch, queue holds three entries
    wait_req("f0", 32'h0, 4);
    respond(ADDI1);
    wait_req("f4", 32'h4, 4);
    respond(ADDI2);
    wait_req("f8", 32'h8, 4);
    respond(ADDI3);
    wait_req("f12", 32'hC, 4);
    pop_chk("pop0", ADDI1, 32'h0, 1'b0);
    pop_chk("pop4", ADDI2, 32'h4, 1'b0);
    pop_chk("pop8", ADDI3, 32'h8, 1'b0);
    @(negedge clk);
    check("idle_iss", {31'b0, iss_vld}, 32'd0);
    check("idle_hold_pc", pc_o, 32'h8);

    // clear while the request to 0xC is in flight: late response dropped
    clr = 1'b1;
    clr_pc = 32'h100;
    @(negedge clk);
    clr = 1'b0;
    check("clr_req", {31'b0, ic_req}, 32'd0);
    iss_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drop_noreq", {31'b0, ic_req}, 32'd0);
    check("drop_empty", {31'b0, iss_vld}, 32'd0);
    respond(NOP);
    wait_req("redir", 32'h100, 3);
    check("redir_empty", {31'b0, iss_vld}, 32'd0);
    iss_rdy = 1'b0;

    // jumps and return
    respond(JMP_M);
    pop_chk("jmp_back", JMP_M, 32'h100, 1'b1);
    wait_req("jtgt", 32'h20, 4);
    respond(JAL16);
    pop_chk("jal", JAL16, 32'h20, 1'b1);
    wait_req("jal_tgt", 32'h30, 4);
    respond(RET);
    pop_chk("ret", RET, 32'h30, RET_BP);
    wait_req("ret_tgt", RET_PC, 4);

    // branch at 0x40: three taken commits saturate high
    commit(32'h40, 1'b1);
    commit(32'h40, 1'b1);
    commit(32'h40, 1'b1);
    respond(jal_enc(5'd0, 32'h40 - RET_PC));
    pop_chk("to40", jal_enc(5'd0, 32'h40 - RET_PC), RET_PC, 1'b1);
    wait_req("br_a", 32'h40, 4);
    respond(BEQ20);
    pop_chk("br_t", BEQ20, 32'h40, 1'b1);
    wait_req("br_t_tgt", 32'h60, 4);

    // four not-taken then one taken: 3->0 (saturated) ->1, weakly not-taken
    commit(32'h40, 1'b0);
    commit(32'h40, 1'b0);
    commit(32'h40, 1'b0);
    commit(32'h40, 1'b0);
    commit(32'h40, 1'b1);
    respond(jal_enc(5'd0, 32'hFFFF_FFE0));
    pop_chk("back40", jal_enc(5'd0, 32'hFFFF_FFE0), 32'h60, 1'b1);
    wait_req("br_b", 32'h40, 4);
    respond(BEQ20);
    pop_chk("br_nt", BEQ20, 32'h40, 1'b0);
    wait_req("br_nt_tgt", 32'h44, 4);

    // clear coinciding with the response: discarded, no drop pending
    clr = 1'b1;
    clr_pc = 32'h200;
    ic_vld = 1'b1;
    ic_d = NOP;
    @(negedge clk);
    clr = 1'b0;
    ic_vld = 1'b0;
    check("clrresp_req", {31'b0, ic_req}, 32'd0);
    check("clrresp_iss", {31'b0, iss_vld}, 32'd0);
    @(negedge clk);
    check("clrresp_next", {31'b0, ic_req}, 32'd1);
    check("clrresp_addr", ic_a, 32'h200);

    // fill the queue
    respond(ADDI1);
    wait_req("fill1", 32'h204, 4);
    respond(ADDI2);
    wait_req("fill2", 32'h208, 4);
    respond(ADDI3);
    wait_req("fill3", 32'h20C, 4);
    respond(NOP);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ic_req) seen++;
      @(negedge clk);
    end
    check("full_noreq", seen, 0);
    pop_chk("full_pop", ADDI1, 32'h200, 1'b0);
    wait_req("after_pop", 32'h210, 2);

    // reset mid-fetch re-initialises pc and BHT
    commit(32'h40, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    outs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("rst_f0", 32'h0, 4);
    respond(jal_enc(5'd0, 32'h40));
    pop_chk("rst_jal", jal_enc(5'd0, 32'h40), 32'h0, 1'b1);
    wait_req("rst_br", 32'h40, 4);
    respond(BEQ20);
    pop_chk("rst_br", BEQ20, 32'h40, 1'b0);
    wait_req("rst_br_tgt", 32'h44, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
